// File: rtl/req_gnt_rr_arbiter_if.sv
// Bundles the master-side req/data/gnt lines with the shared slave's req/data/gnt and status.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the slave model.
interface req_gnt_rr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic                    slv_req;
  logic [DATA_W-1:0]       slv_data;
  logic                    slv_gnt;
  logic                    busy;
  logic [OW-1:0]           owner;
  logic                    timeout;

  modport slave (
    input  req, data, slv_gnt,
    output gnt, slv_req, slv_data, busy, owner, timeout
  );

  modport master (
    output req, data, slv_gnt,
    input  gnt, slv_req, slv_data, busy, owner, timeout
  );
endinterface

// File: rtl/req_gnt_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt slave among N_REQ masters, with one transfer in flight and registered outputs.
// Latency is req -> slv_req in 1 cycle and slv_gnt -> gnt in 1 cycle. An unanswered slv_req is abandoned after MAX_WAIT cycles.
module req_gnt_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  req_gnt_rr_arbiter_if.slave  bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] slv_data_q, slv_data_d;
  logic              slv_req_q, slv_req_d;
  logic              timeout_q, timeout_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic              found;
  logic [OW-1:0]     win;
  logic [DATA_W-1:0] win_data;
  logic [OW-1:0]     owner_inc;
  logic              wait_expired;

  // Rotating priority search: the first requester at or after ptr wins.
  always_comb begin : pick
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[OW'(idx)]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  always_comb begin : pick_data
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == OW'(i)) win_data = bus.data[i*DATA_W +: DATA_W];
    end
  end

  assign owner_inc    = (owner_q == OW'(N_REQ-1)) ? '0 : owner_q + OW'(1);
  assign wait_expired = (MAX_WAIT != 0) && (wait_cnt_q == CW'(MAX_WAIT-1));

  always_comb begin : fsm
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    slv_data_d = slv_data_q;
    slv_req_d  = slv_req_q;
    gnt_d      = '0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = win;
          slv_data_d = win_data;
          slv_req_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // An accept on the final wait cycle takes priority over the timeout.
        if (bus.slv_gnt) begin
          slv_req_d = 1'b0;
          gnt_d     = N_REQ'(1) << owner_q;
          ptr_d     = owner_inc;
          state_d   = DONE;
        end else if (wait_expired) begin
          slv_req_d = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = owner_inc;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      wait_cnt_q <= '0;
      slv_data_q <= '0;
      slv_req_q  <= 1'b0;
      timeout_q  <= 1'b0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      slv_data_q <= slv_data_d;
      slv_req_q  <= slv_req_d;
      timeout_q  <= timeout_d;
      gnt_q      <= gnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.slv_req  = slv_req_q;
  assign bus.slv_data = slv_data_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// Testbench for req_gnt_rr_arbiter: directed scenarios plus randomized traffic.
// Results are compared against a transaction-level model of the arbitration rules.
module tb_req_gnt_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MW = 15;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] mdat [N];
  int checks = 0;
  int failures = 0;

  req_gnt_rr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  req_gnt_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always_comb bus.data = {mdat[3], mdat[2], mdat[1], mdat[0]};

  // Transaction-level reference: phase 0 = free, 1 = slave requested, 2 = granted.
  int          m_phase, m_ptr, m_own, m_cyc, m_start;
  logic [N-1:0]  e_gnt;
  logic          e_slvreq, e_to;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_own = 0; m_start = 0;
    e_gnt = '0; e_slvreq = 1'b0; e_to = 1'b0; e_data = '0;
  endtask

  task automatic model_edge();
    bit got;
    m_cyc++;
    e_gnt = '0;
    e_to  = 1'b0;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (bus.slv_gnt) begin
        e_slvreq = 1'b0;
        e_gnt    = N'(1) << m_own;
        m_ptr    = (m_own + 1) % N;
        m_phase  = 2;
      end else if (MW != 0 && (m_cyc - m_start) == MW) begin
        e_slvreq = 1'b0;
        e_to     = 1'b1;
        m_ptr    = (m_own + 1) % N;
        m_phase  = 0;
      end
    end else begin
      got = 1'b0;
      for (int i = 0; i < N; i++) begin
        int w;
        w = (m_ptr + i) % N;
        if (!got && bus.req[w]) begin
          got      = 1'b1;
          m_own    = w;
          e_data   = mdat[w];
          e_slvreq = 1'b1;
          m_start  = m_cyc;
          m_phase  = 1;
        end
      end
    end
  endtask

  function automatic logic [16:0] exp_vec();
    return {e_gnt, e_slvreq, (e_slvreq ? e_data : 8'h00),
            ((m_phase != 0) ? 2'(m_own) : 2'b00), (m_phase != 0), e_to};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.gnt, bus.slv_req, (e_slvreq ? bus.slv_data : 8'h00),
            ((m_phase != 0) ? bus.owner : 2'b00), bus.busy, bus.timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.slv_gnt = 1'b0;
    for (int i = 0; i < N; i++) mdat[i] = '0;
    rst = 1'b1;
    model_reset();
    #6;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.slv_gnt = 1'b0;
    for (int i = 0; i < N; i++) mdat[i] = '0;
    rst = 1'b1; m_cyc = 0;
    model_reset();
    #1;
    checks++;
    if ({bus.gnt, bus.slv_req, bus.slv_data, bus.owner, bus.busy, bus.timeout} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.gnt, bus.slv_req, bus.slv_data, bus.owner, bus.busy, bus.timeout});
    end
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0001; mdat[0] = 8'hA5;
    tick();
    checks++;
    if (bus.slv_req !== 1'b1 || bus.slv_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_req got=%b/%h exp=1/a5", bus.slv_req, bus.slv_data);
    end
    bus.slv_gnt = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.slv_req !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL single_gnt got gnt=%b slv_req=%b exp gnt=0001 slv_req=0", bus.gnt, bus.slv_req);
    end
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt_pulse got gnt=%b busy=%b exp 0000/0", bus.gnt, bus.busy);
    end
    bus.req = 4'b1111;
    tick();
    checks++;
    if (bus.owner !== 2'd1) begin
      failures++;
      $display("FAIL single_ptr got owner=%0d exp=1", bus.owner);
    end
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int last;
    logic [N-1:0] reraise;
    do_reset();
    for (int i = 0; i < N; i++) mdat[i] = 8'($urandom);
    bus.req = 4'b1111; bus.slv_gnt = 1'b1;
    reraise = '0; last = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      bus.req = bus.req | reraise;
      reraise = '0;
      if (bus.gnt != '0) begin
        for (int i = 0; i < N; i++) if (bus.gnt[i]) order.push_back(i);
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=3", c - last);
          end
        end
        last = c;
        bus.req = bus.req & ~bus.gnt;
        reraise = bus.gnt;
      end
    end
    checks++;
    if (order.size() < 6) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp>=6", order.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (order[i] !== exp_order[i]) begin
          failures++;
          $display("FAIL b2b_order i=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
        end
      end
    end
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b0100;
    tick();
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick();
    bus.req = 4'b0101;
    tick();
    checks++;
    if (bus.owner !== 2'd0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL wrap_first got owner=%0d exp=0", bus.owner);
    end
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = 4'b0100; bus.slv_gnt = 1'b0;
    tick(); tick();
    checks++;
    if (bus.owner !== 2'd2 || bus.slv_req !== 1'b1) begin
      failures++;
      $display("FAIL wrap_second got owner=%0d slv_req=%b exp 2/1", bus.owner, bus.slv_req);
    end
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int hi, pulses, gnts;
    bit seen;
    hi = 0; pulses = 0; gnts = 0; seen = 0;
    bus.req = 4'b0010; bus.slv_gnt = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL timeout_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (bus.slv_req) hi++;
      if (bus.gnt != '0) gnts++;
      if (bus.timeout) begin
        pulses++; seen = 1;
        checks++;
        if (bus.busy !== 1'b0) begin
          failures++;
          $display("FAIL timeout_busy got=%b exp=0", bus.busy);
        end
        bus.req = '0;
      end
    end
    checks++;
    if (hi != MW || pulses != 1 || gnts != 0) begin
      failures++;
      $display("FAIL timeout_len got hi=%0d pulses=%0d gnts=%0d exp %0d/1/0", hi, pulses, gnts, MW);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width got=%b exp=0", bus.timeout);
    end
    bus.req = 4'b0110;
    tick();
    checks++;
    if (bus.owner !== 2'd2) begin
      failures++;
      $display("FAIL timeout_ptr got owner=%0d exp=2", bus.owner);
    end
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick();
  endtask

  task automatic test_late_gnt();
    bus.req = 4'b0001; mdat[0] = 8'h3C;
    for (int k = 1; k <= MW; k++) begin
      tick();
      checks++;
      if (bus.slv_req !== 1'b1 || bus.slv_data !== 8'h3C || bus.timeout !== 1'b0) begin
        failures++;
        $display("FAIL late_hold k=%0d got slv_req=%b data=%h to=%b exp 1/3c/0", k, bus.slv_req, bus.slv_data, bus.timeout);
      end
      if (k == 3) begin bus.req = '0; mdat[0] = 8'hC3; end
      if (k == MW) bus.slv_gnt = 1'b1;
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL late_gnt got gnt=%b to=%b exp 0001/0", bus.gnt, bus.timeout);
    end
    bus.slv_gnt = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0100; mdat[2] = 8'h5A;
    tick(); tick(); tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({bus.gnt, bus.slv_req, bus.busy, bus.timeout} !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0", {bus.gnt, bus.slv_req, bus.busy, bus.timeout});
    end
    #2;
    bus.req = 4'b1010;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.owner !== 2'd1 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_ptr got owner=%0d exp=1", bus.owner);
    end
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = 4'b1000; bus.slv_gnt = 1'b0;
    tick(); tick();
    checks++;
    if (bus.owner !== 2'd3 || bus.slv_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_winner3 got owner=%0d exp=3", bus.owner);
    end
    bus.slv_gnt = 1'b1;
    tick();
    bus.req = '0; bus.slv_gnt = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int pct;
    int pcts[3] = '{0, 15, 60};
    do_reset();
    for (int c = 0; c < 900; c++) begin
      if (c % 60 == 0) pct = pcts[$urandom_range(0, 2)];
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || $countones(bus.gnt) > 1) begin
        failures++;
        $display("FAIL random_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      bus.req = bus.req & ~bus.gnt;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && !bus.gnt[i] && $urandom_range(0, 99) < 30) bus.req[i] = 1'b1;
        if ($urandom_range(0, 99) < 20) mdat[i] = 8'($urandom);
      end
      if (bus.busy && $urandom_range(0, 99) < 3) bus.req[bus.owner] = 1'b0;
      bus.slv_gnt = ($urandom_range(0, 99) < pct);
    end
    bus.req = '0; bus.slv_gnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_late_gnt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
